// File: rtl/aexm_memu.sv
// aexm_memu: memory-access stage of the aexm pipeline.
// Captures an access from execute, runs one request/acknowledge data-bus
// transaction while holding the pipeline, and aligns load data for
// write-back and operand forwarding. Data path is fixed at 32 bits.
`timescale 1ns/1ps
module aexm_memu #(
    parameter int DW  = 32,   // only 32 is supported
    parameter int TMO = 255   // acknowledge wait limit, 1..255
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          x_en,
    input  logic          xLD,
    input  logic          xST,
    input  logic [DW-1:0] rRESULT,
    input  logic [3:0]    rDWBSEL,
    input  logic [DW-1:0] xREGD,
    input  logic [4:0]    rRD,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [29:0]   dmem_adr,
    output logic [3:0]    dmem_sel,
    output logic [DW-1:0] dmem_dat_o,
    input  logic [DW-1:0] dmem_dat_i,
    input  logic          dmem_ack,
    output logic          mem_stall,
    output logic [DW-1:0] rDWBDI,
    output logic          rWB_EN,
    output logic [4:0]    rWB_RD,
    output logic          rBUS_ERR
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [7:0] TMO_C = 8'(TMO);

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [4:0] rd_q;

    // Byte address bits only steer lanes via rDWBSEL; the bus is word addressed.
    logic unused_adr_lo;
    assign unused_adr_lo = ^rRESULT[1:0];

    logic start;
    assign start = x_en && (xLD || xST) && (rDWBSEL != 4'h0);

    // Replicate the low byte/half of the store data across the active lanes.
    function automatic logic [31:0] store_data(input logic [3:0] sel, input logic [31:0] d);
        case (sel)
            4'h8, 4'h4, 4'h2, 4'h1: store_data = {4{d[7:0]}};
            4'hC, 4'h3:             store_data = {2{d[15:0]}};
            default:                store_data = d;
        endcase
    endfunction

    // Big-endian lane extraction with zero extension.
    function automatic logic [31:0] load_align(input logic [3:0] sel, input logic [31:0] d);
        case (sel)
            4'h8:    load_align = {24'h0, d[31:24]};
            4'h4:    load_align = {24'h0, d[23:16]};
            4'h2:    load_align = {24'h0, d[15:8]};
            4'h1:    load_align = {24'h0, d[7:0]};
            4'hC:    load_align = {16'h0, d[31:16]};
            4'h3:    load_align = {16'h0, d[15:0]};
            default: load_align = d;
        endcase
    endfunction

    // Transaction FSM; every output is registered so ack never reaches
    // mem_stall combinationally, and reset clears req/stall asynchronously.
    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'h0;
            rd_q       <= 5'h0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_adr   <= 30'h0;
            dmem_sel   <= 4'h0;
            dmem_dat_o <= 32'h0;
            mem_stall  <= 1'b0;
            rDWBDI     <= 32'h0;
            rWB_EN     <= 1'b0;
            rWB_RD     <= 5'h0;
            rBUS_ERR   <= 1'b0;
        end else begin
            rWB_EN   <= 1'b0;
            rBUS_ERR <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    // A new access may be taken straight out of DONE.
                    if (start) begin
                        state_q    <= BUSY;
                        cnt_q      <= 8'h0;
                        rd_q       <= rRD;
                        dmem_req   <= 1'b1;
                        mem_stall  <= 1'b1;
                        dmem_we    <= xST;
                        dmem_adr   <= rRESULT[31:2];
                        dmem_sel   <= rDWBSEL;
                        dmem_dat_o <= store_data(rDWBSEL, xREGD);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    // Ack wins over a timeout landing on the same edge.
                    if (dmem_ack) begin
                        state_q   <= DONE;
                        dmem_req  <= 1'b0;
                        mem_stall <= 1'b0;
                        if (!dmem_we) begin
                            rDWBDI <= load_align(dmem_sel, dmem_dat_i);
                            rWB_EN <= 1'b1;
                            rWB_RD <= rd_q;
                        end
                    end else if (cnt_q + 8'd1 == TMO_C) begin
                        state_q   <= IDLE;
                        cnt_q     <= 8'h0;
                        dmem_req  <= 1'b0;
                        mem_stall <= 1'b0;
                        rBUS_ERR  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aexm_memu.sv
// Bench for aexm_memu: table of load/store vectors run back-to-back with a
// bus/write-back scoreboard, plus hand sequences for timeout, sel=0, stray
// ack, x_en during BUSY and asynchronous reset mid-transaction.
`timescale 1ns/1ps
module tb_aexm_memu;

    localparam int TMO = 4;

    logic        gclk = 1'b0;
    logic        grst = 1'b1;
    logic        x_en = 1'b0, xLD = 1'b0, xST = 1'b0;
    logic [31:0] rRESULT = '0, xREGD = '0, dmem_dat_i = '0;
    logic [3:0]  rDWBSEL = '0;
    logic [4:0]  rRD = '0;
    logic        resp_ack = 1'b0, stray_ack = 1'b0, dmem_ack;
    logic        dmem_req, dmem_we, mem_stall, rWB_EN, rBUS_ERR;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_sel;
    logic [31:0] dmem_dat_o, rDWBDI;
    logic [4:0]  rWB_RD;

    assign dmem_ack = resp_ack | stray_ack;

    aexm_memu #(.DW(32), .TMO(TMO)) dut (
        .gclk(gclk), .grst(grst), .x_en(x_en), .xLD(xLD), .xST(xST),
        .rRESULT(rRESULT), .rDWBSEL(rDWBSEL), .xREGD(xREGD), .rRD(rRD),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_adr(dmem_adr),
        .dmem_sel(dmem_sel), .dmem_dat_o(dmem_dat_o), .dmem_dat_i(dmem_dat_i),
        .dmem_ack(dmem_ack), .mem_stall(mem_stall), .rDWBDI(rDWBDI),
        .rWB_EN(rWB_EN), .rWB_RD(rWB_RD), .rBUS_ERR(rBUS_ERR)
    );

    always #5 gclk = ~gclk;

    typedef struct {
        bit          ld;
        bit          st;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] wd;
        logic [31:0] rdat;
        logic [4:0]  rd;
        int          waits;
        logic [29:0] exp_adr;
        logic [31:0] exp_dato;
        logic [31:0] exp_di;
    } vec_t;

    typedef struct { logic we; logic [29:0] adr; logic [3:0] sel; logic [31:0] dat; } bus_t;
    typedef struct { logic [4:0] rd; logic [31:0] dat; } wb_t;

    bus_t bq[$];
    wb_t  wq[$];
    vec_t vecs[11];
    vec_t pv, tv, rv;

    int          errors = 0, checks = 0, buserr_cnt = 0;
    int          resp_waits = 0;
    bit          resp_en = 1'b1;
    logic [31:0] resp_data = '0;
    logic [31:0] prev_di;
    int          n;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(bit ld, logic [31:0] adr, logic [3:0] sel, logic [31:0] wd,
                                 logic [31:0] rdat, logic [4:0] rd, int waits,
                                 logic [29:0] ea, logic [31:0] edo, logic [31:0] edi);
        vec_t v;
        v.ld = ld; v.st = !ld; v.adr = adr; v.sel = sel; v.wd = wd; v.rdat = rdat;
        v.rd = rd; v.waits = waits; v.exp_adr = ea; v.exp_dato = edo; v.exp_di = edi;
        return v;
    endfunction

    // Memory model: acks after resp_waits wait states while enabled.
    task automatic responder();
        int wcnt = 0;
        forever begin
            @(negedge gclk);
            resp_ack = 1'b0;
            if (dmem_req && resp_en && !grst) begin
                if (wcnt == resp_waits) begin
                    resp_ack = 1'b1; dmem_dat_i = resp_data; wcnt = 0;
                end else wcnt++;
            end else wcnt = 0;
        end
    endtask

    // Scoreboard: bus requests and write-backs against queued expectations.
    task automatic monitor();
        bus_t e;
        wb_t  w;
        bit   req_prev = 1'b0;
        forever begin
            @(negedge gclk);
            if (grst) begin
                req_prev = 1'b0;
            end else begin
                if (mem_stall || dmem_req) chk("stall_eq_req", {31'h0, mem_stall}, {31'h0, dmem_req});
                if (dmem_req && !req_prev) begin
                    if (bq.size() == 0) chk("unexpected_req", 32'h1, 32'h0);
                    else begin
                        e = bq.pop_front();
                        chk("bus_we",  {31'h0, dmem_we}, {31'h0, e.we});
                        chk("bus_adr", {2'h0, dmem_adr}, {2'h0, e.adr});
                        chk("bus_sel", {28'h0, dmem_sel}, {28'h0, e.sel});
                        chk("bus_dat", dmem_dat_o, e.dat);
                    end
                end else if (dmem_req) begin
                    chk("stable_we",  {31'h0, dmem_we}, {31'h0, e.we});
                    chk("stable_adr", {2'h0, dmem_adr}, {2'h0, e.adr});
                    chk("stable_sel", {28'h0, dmem_sel}, {28'h0, e.sel});
                    chk("stable_dat", dmem_dat_o, e.dat);
                end
                if (rWB_EN) begin
                    if (wq.size() == 0) chk("unexpected_wb", 32'h1, 32'h0);
                    else begin
                        w = wq.pop_front();
                        chk("wb_rd",  {27'h0, rWB_RD}, {27'h0, w.rd});
                        chk("wb_dat", rDWBDI, w.dat);
                    end
                end
                if (rBUS_ERR) buserr_cnt++;
                req_prev = dmem_req;
            end
        end
    endtask

    // Issue one access at the current negedge and wait until the stall drops.
    // poke raises x_en with a bogus store while BUSY; it must be ignored.
    task automatic run_vec(input vec_t v, input bit poke);
        int k;
        prev_di    = rDWBDI;
        resp_waits = v.waits; resp_data = v.rdat;
        x_en = 1'b1; xLD = v.ld; xST = v.st; rRESULT = v.adr; rDWBSEL = v.sel;
        xREGD = v.wd; rRD = v.rd;
        bq.push_back('{v.st, v.exp_adr, v.sel, v.exp_dato});
        if (v.ld) wq.push_back('{v.rd, v.exp_di});
        k = 0;
        do begin
            @(negedge gclk);
            k++;
            x_en = 1'b0; xLD = 1'b0; xST = 1'b0;
            if (poke && k == 1) begin
                x_en = 1'b1; xST = 1'b1; rRESULT = 32'hFFFF_0000; rDWBSEL = 4'hF;
            end
        end while (mem_stall && k < 40);
        x_en = 1'b0; xST = 1'b0;
        chk("latency", k, v.waits + 2);
        if (v.st) chk("store_keeps_di", rDWBDI, prev_di);
    endtask

    initial begin
        vecs[0]  = mkv(1, 32'h0000_0100, 4'h4, 32'h0000_00AA, 32'h1122_3344, 5'd5,  0, 30'h40,        32'hAAAA_AAAA, 32'h0000_0022);
        vecs[1]  = mkv(0, 32'h2000_0006, 4'h3, 32'hDEAD_BEEF, 32'h0,         5'd0,  3, 30'h0800_0001, 32'hBEEF_BEEF, 32'h0);
        vecs[2]  = mkv(1, 32'h0000_0204, 4'hC, 32'h1234_5678, 32'hA1B2_C3D4, 5'd7,  1, 30'h81,        32'h5678_5678, 32'h0000_A1B2);
        vecs[3]  = mkv(1, 32'h0000_0206, 4'h3, 32'h0,         32'hA1B2_C3D4, 5'd8,  0, 30'h81,        32'h0,         32'h0000_C3D4);
        vecs[4]  = mkv(1, 32'h0000_0300, 4'h8, 32'h0000_00FF, 32'hA1B2_C3D4, 5'd9,  2, 30'hC0,        32'hFFFF_FFFF, 32'h0000_00A1);
        vecs[5]  = mkv(1, 32'h0000_0302, 4'h2, 32'h0000_0001, 32'hA1B2_C3D4, 5'd10, 0, 30'hC0,        32'h0101_0101, 32'h0000_00C3);
        vecs[6]  = mkv(1, 32'h0000_0303, 4'h1, 32'h0,         32'hA1B2_C3D4, 5'd31, 1, 30'hC0,        32'h0,         32'h0000_00D4);
        vecs[7]  = mkv(1, 32'hFFFF_FFFC, 4'hF, 32'hCAFE_F00D, 32'h89AB_CDEF, 5'd1,  0, 30'h3FFF_FFFF, 32'hCAFE_F00D, 32'h89AB_CDEF);
        vecs[8]  = mkv(0, 32'h0000_1001, 4'h1, 32'h1234_5678, 32'h0,         5'd0,  0, 30'h400,       32'h7878_7878, 32'h0);
        vecs[9]  = mkv(0, 32'h0000_0400, 4'hF, 32'h0BAD_C0DE, 32'h0,         5'd0,  2, 30'h100,       32'h0BAD_C0DE, 32'h0);
        vecs[10] = mkv(0, 32'h0000_0008, 4'h8, 32'h0000_00AB, 32'h0,         5'd0,  1, 30'h2,         32'hABAB_ABAB, 32'h0);
        pv = mkv(1, 32'h0000_0040, 4'hF, 32'h0, 32'h55AA_55AA, 5'd12, 3, 30'h10,  32'h0,         32'h55AA_55AA);
        tv = mkv(1, 32'h0000_0600, 4'hF, 32'h0, 32'h0,         5'd3,  0, 30'h180, 32'h0,         32'h0);
        rv = mkv(1, 32'h0000_0500, 4'h3, 32'h0000_1234, 32'h0, 5'd4,  0, 30'h140, 32'h1234_1234, 32'h0);

        fork
            responder();
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state, asynchronously and across clock edges.
        #3;
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        repeat (2) @(negedge gclk);
        chk("rst_we", {31'h0, dmem_we}, 32'h0);
        chk("rst_adr", {2'h0, dmem_adr}, 32'h0);
        chk("rst_sel", {28'h0, dmem_sel}, 32'h0);
        chk("rst_dato", dmem_dat_o, 32'h0);
        chk("rst_di", rDWBDI, 32'h0);
        chk("rst_wben", {31'h0, rWB_EN}, 32'h0);
        chk("rst_wbrd", {27'h0, rWB_RD}, 32'h0);
        chk("rst_buserr", {31'h0, rBUS_ERR}, 32'h0);
        grst = 1'b0;
        @(negedge gclk);

        // Table vectors, issued back-to-back so each capture lands in DONE.
        for (int i = 0; i < 11; i++) run_vec(vecs[i], 1'b0);
        @(negedge gclk);

        // rDWBSEL == 0: nothing issued.
        x_en = 1'b1; xLD = 1'b1; rDWBSEL = 4'h0; rRESULT = 32'h700;
        for (int i = 0; i < 5; i++) begin
            @(negedge gclk);
            x_en = 1'b0; xLD = 1'b0;
            chk("sel0_req", {31'h0, dmem_req}, 32'h0);
            chk("sel0_stall", {31'h0, mem_stall}, 32'h0);
        end

        // Stray ack while idle, then x_en poked during BUSY.
        prev_di = rDWBDI;
        stray_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge gclk);
            chk("stray_req", {31'h0, dmem_req}, 32'h0);
            chk("stray_wben", {31'h0, rWB_EN}, 32'h0);
            chk("stray_di", rDWBDI, prev_di);
        end
        stray_ack = 1'b0;
        @(negedge gclk);
        run_vec(pv, 1'b1);
        @(negedge gclk);
        chk("poke_idle_req", {31'h0, dmem_req}, 32'h0);

        // Timeout: load never acknowledged.
        resp_en = 1'b0;
        prev_di = rDWBDI;
        x_en = 1'b1; xLD = 1'b1; rRESULT = tv.adr; rDWBSEL = tv.sel; xREGD = tv.wd; rRD = tv.rd;
        bq.push_back('{1'b0, tv.exp_adr, tv.sel, tv.exp_dato});
        n = 0;
        do begin
            @(negedge gclk);
            n++;
            x_en = 1'b0; xLD = 1'b0;
        end while (mem_stall && n < 40);
        chk("tmo_cycles", n, TMO + 1);
        chk("tmo_err", {31'h0, rBUS_ERR}, 32'h1);
        chk("tmo_req", {31'h0, dmem_req}, 32'h0);
        chk("tmo_wben", {31'h0, rWB_EN}, 32'h0);
        @(negedge gclk);
        chk("tmo_err_clr", {31'h0, rBUS_ERR}, 32'h0);
        chk("tmo_di", rDWBDI, prev_di);
        chk("tmo_idle", {31'h0, mem_stall}, 32'h0);
        resp_en = 1'b1;

        // Reset between edges during BUSY.
        resp_en = 1'b0;
        x_en = 1'b1; xLD = 1'b1; rRESULT = rv.adr; rDWBSEL = rv.sel; xREGD = rv.wd; rRD = rv.rd;
        bq.push_back('{1'b0, rv.exp_adr, rv.sel, rv.exp_dato});
        @(negedge gclk);
        x_en = 1'b0; xLD = 1'b0;
        @(negedge gclk);
        chk("pre_rst_req", {31'h0, dmem_req}, 32'h1);
        #2 grst = 1'b1;
        #1;
        chk("async_rst_req", {31'h0, dmem_req}, 32'h0);
        chk("async_rst_stall", {31'h0, mem_stall}, 32'h0);
        chk("async_rst_di", rDWBDI, 32'h0);
        @(negedge gclk);
        grst = 1'b0; resp_en = 1'b1;
        @(negedge gclk);
        run_vec(vecs[0], 1'b0);
        @(negedge gclk);

        chk("bq_empty", bq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        chk("buserr_count", buserr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aexm_memu.md
# aexm_memu

Memory-access stage of the aexm pipeline, directly downstream of the execute unit. Captures the effective address, byte-lane select and store data when execute advances, runs one data-bus transaction with a request/acknowledge handshake, and stalls the pipeline while the transaction is outstanding. For loads it aligns and zero-extends the returned data and issues a one-cycle register write-back; the aligned data also feeds back as the execute operand-forward input.

## Interface
- DW, 32, data bus width; only 32 is supported.
- TMO, 255, maximum acknowledge wait in cycles before the transaction is aborted; 1..255.

- gclk  in  1  clock; all state changes on rising edge.
- grst  in  1  reset, asynchronous, active-high.
- x_en  in  1  execute-stage advance; inputs are sampled when high.
- xLD  in  1  advancing instruction is a load.
- xST  in  1  advancing instruction is a store; xLD and xST are never both high.
- rRESULT  in  32  effective address from execute.
- rDWBSEL  in  4  byte lanes from execute: 8/4/2/1 byte, C/3 half, F word, 0 no access.
- xREGD  in  32  raw store data (low byte/half significant).
- rRD  in  5  load destination register.
- dmem_req  out  1  transaction request.
- dmem_we  out  1  1 = write.
- dmem_adr  out  30  word address, rRESULT[31:2].
- dmem_sel  out  4  byte enables.
- dmem_dat_o  out  32  lane-replicated store data.
- dmem_dat_i  in  32  read data, valid with dmem_ack.
- dmem_ack  in  1  transaction complete.
- mem_stall  out  1  pipeline hold; upstream keeps x_en low while high.
- rDWBDI  out  32  aligned load data.
- rWB_EN  out  1  one-cycle register write-back strobe.
- rWB_RD  out  5  write-back register number.
- rBUS_ERR  out  1  one-cycle timeout pulse.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if x_en & (xLD|xST) & rDWBSEL!=0, latch address, sel, we=xST, rRD and store data; go BUSY. If rDWBSEL==0, nothing is issued and the stage stays IDLE.
- Store data: byte lane = {4{xREGD[7:0]}}; half = {2{xREGD[15:0]}}; word = xREGD.
- BUSY: dmem_req=1 and mem_stall=1. Address, sel, we and data stay stable. The wait counter increments every cycle.
  - On dmem_ack go DONE. For a load, latch aligned data into rDWBDI.
  - If the counter reaches TMO without an ack, drop req, pulse rBUS_ERR, leave rDWBDI unchanged, no write-back, go IDLE.
- Alignment is big-endian; lane 8 = dat[31:24] and lane 1 = dat[7:0].
  - Byte result = {24'h0, selected byte}.
  - Half result: C -> dat[31:16]; 3 -> dat[15:0], zero-extended.
  - Word result passes through unchanged.
- DONE: one cycle. rWB_EN=1 for loads only, with rWB_RD = latched rRD. Return to IDLE. A new request may be captured in DONE if x_en is high; in that case go BUSY.
- dmem_ack in IDLE or DONE is ignored. x_en in BUSY is ignored.
- Reset values:
  - All outputs 0; rDWBDI=0; state IDLE; counter 0.
  - Reset asserted mid-transaction drops dmem_req and mem_stall immediately, without waiting for a clock edge.

## Timing
- Capture edge N (x_en high in IDLE) puts dmem_req high from N to the ack edge.
- Earliest ack is sampled at edge N+1. That gives DONE during N+1..N+2 and rWB_EN high for that one cycle, with rDWBDI valid from edge N+1.
- Each wait state adds one cycle.
- mem_stall equals state==BUSY; it is registered, with no combinational path from dmem_ack.
- Timeout: if no ack arrives, rBUS_ERR pulses in the cycle after edge N+TMO and req is low by then.
- Back-to-back throughput: one access per two cycles (BUSY+DONE) with zero wait states.

## Test plan
- Byte load, zero wait: rRESULT=0x100, sel=4, dat_i=0x11223344 ack at N+1 -> dmem_adr=0x40, rDWBDI=0x00000022, rWB_EN one cycle with rWB_RD=rRD.
- Half store, 3 wait states: sel=3, xREGD=0xDEADBEEF -> dat_o=0xBEEFBEEF, we=1, req high 4 cycles, stable; no rWB_EN.
- Timeout with TMO=4: load with no ack -> rBUS_ERR one pulse, req low, rDWBDI unchanged, no rWB_EN, stage back in IDLE.
- sel=0 load -> dmem_req never rises, mem_stall stays 0.
- Reset asserted between clock edges during BUSY -> req and mem_stall go to 0 immediately; after release the next load proceeds normally.
- Stray ack in IDLE plus x_en pulse during BUSY -> no state change, no extra transaction.
